// File: rtl/active_list_if.sv
// rtl/active_list_if.sv - active list rename/completion/flush/commit bundle
interface active_list_if #(
  parameter int DEPTH        = 32,
  parameter int COMMIT_WIDTH = 2,
  parameter int NUM_DONE     = 2,
  parameter int PREG_IDX     = 6,
  parameter int ADDR_WIDTH   = 32
);
  localparam int IW = $clog2(DEPTH);

  logic                             alloc_valid;
  logic                             alloc_ready;
  logic [ADDR_WIDTH-1:0]            alloc_pc;
  logic                             alloc_uses_rw;
  logic [PREG_IDX-1:0]              alloc_rw_addr;
  logic [PREG_IDX-1:0]              alloc_reclaim;
  logic                             alloc_is_load;
  logic                             alloc_is_store;
  logic [IW-1:0]                    alloc_id;
  logic                             alloc_color;
  logic [NUM_DONE-1:0]              done_valid;
  logic [NUM_DONE*IW-1:0]           done_id;
  logic                             flush_valid;
  logic [IW-1:0]                    flush_id;
  logic                             flush_color;
  logic [COMMIT_WIDTH-1:0]          commit_valid;
  logic [COMMIT_WIDTH*IW-1:0]       commit_id;
  logic [COMMIT_WIDTH-1:0]          commit_uses_rw;
  logic [COMMIT_WIDTH*PREG_IDX-1:0] commit_reclaim;
  logic [COMMIT_WIDTH-1:0]          commit_is_store;
  logic [COMMIT_WIDTH*ADDR_WIDTH-1:0] commit_pc;
  logic [IW:0]                      count;
  logic                             empty;
  logic                             full;
  logic [31:0]                      stat_commits;
  logic [31:0]                      stat_flushes;
  logic [31:0]                      stat_full_cycles;

  modport master (
    output alloc_valid, alloc_pc, alloc_uses_rw, alloc_rw_addr, alloc_reclaim,
           alloc_is_load, alloc_is_store, done_valid, done_id,
           flush_valid, flush_id, flush_color,
    input  alloc_ready, alloc_id, alloc_color, commit_valid, commit_id,
           commit_uses_rw, commit_reclaim, commit_is_store, commit_pc,
           count, empty, full, stat_commits, stat_flushes, stat_full_cycles
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_uses_rw, alloc_rw_addr, alloc_reclaim,
           alloc_is_load, alloc_is_store, done_valid, done_id,
           flush_valid, flush_id, flush_color,
    output alloc_ready, alloc_id, alloc_color, commit_valid, commit_id,
           commit_uses_rw, commit_reclaim, commit_is_store, commit_pc,
           count, empty, full, stat_commits, stat_flushes, stat_full_cycles
  );
endinterface

// File: rtl/active_list_unit.sv
// rtl/active_list_unit.sv - in-order retire reorder buffer with colored branch squash; optional ACTIVE_LIST_STATS_EN counters
module active_list_unit #(
  parameter int DEPTH        = 32,
  parameter int COMMIT_WIDTH = 2,
  parameter int NUM_DONE     = 2,
  parameter int PREG_IDX     = 6,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  active_list_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  // Pointers carry a color MSB so full and empty are distinguishable.
  logic [PW-1:0]         head, tail, count, n_commit;
  logic [IW-1:0]         tail_idx, fl_off;
  logic                  flush_accept, do_alloc, chain;
  logic [NUM_DONE-1:0]   done_ok;
  logic [IW-1:0]         done_off [NUM_DONE];
  logic [IW-1:0]         slot_id  [COMMIT_WIDTH];

  logic [ADDR_WIDTH-1:0] ent_pc      [DEPTH];
  logic [PREG_IDX-1:0]   ent_reclaim [DEPTH];
  logic [DEPTH-1:0]      ent_color, ent_uses_rw, ent_is_store, done_bits;

  assign tail_idx        = tail[IW-1:0];
  assign do_alloc        = bus.alloc_valid && bus.alloc_ready;
  assign bus.count       = count;
  assign bus.empty       = (count == '0);
  assign bus.full        = (count == PW'(DEPTH));
  assign bus.alloc_ready = !bus.full && !bus.flush_valid;
  assign bus.alloc_id    = tail_idx;
  assign bus.alloc_color = tail[IW];

  // Liveness of flush/done targets, and the in-order retire window clipped at an accepted branch.
  always_comb begin
    count        = tail - head;
    fl_off       = bus.flush_id - head[IW-1:0];
    flush_accept = bus.flush_valid && ({1'b0, fl_off} < count) &&
                   (ent_color[bus.flush_id] == bus.flush_color);
    done_ok = '0;
    for (int k = 0; k < NUM_DONE; k++) begin
      done_off[k] = bus.done_id[k*IW +: IW] - head[IW-1:0];
      done_ok[k]  = ({1'b0, done_off[k]} < count) &&
                    (!flush_accept || (done_off[k] <= fl_off));
    end
    chain              = 1'b1;
    n_commit           = '0;
    bus.commit_valid   = '0;
    bus.commit_id      = '0;
    bus.commit_uses_rw = '0;
    bus.commit_reclaim = '0;
    bus.commit_is_store = '0;
    bus.commit_pc      = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      slot_id[j] = head[IW-1:0] + IW'(j);
      chain = chain && (PW'(j) < count) && done_bits[slot_id[j]] &&
              (!flush_accept || (PW'(j) <= {1'b0, fl_off}));
      bus.commit_valid[j]                       = chain;
      bus.commit_id[j*IW +: IW]                 = slot_id[j];
      bus.commit_uses_rw[j]                     = ent_uses_rw[slot_id[j]];
      bus.commit_reclaim[j*PREG_IDX +: PREG_IDX] = ent_reclaim[slot_id[j]];
      bus.commit_is_store[j]                    = ent_is_store[slot_id[j]];
      bus.commit_pc[j*ADDR_WIDTH +: ADDR_WIDTH] = ent_pc[slot_id[j]];
      n_commit = n_commit + PW'(chain);
    end
  end

  // Pointer movement and done tracking; a flush rebuilds tail from head so the branch stays live.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      done_bits <= '0;
    end else begin
      head <= head + n_commit;
      if (flush_accept)
        tail <= head + PW'(fl_off) + PW'(1);
      else if (do_alloc)
        tail <= tail + PW'(1);
      for (int k = 0; k < NUM_DONE; k++)
        if (bus.done_valid[k] && done_ok[k])
          done_bits[bus.done_id[k*IW +: IW]] <= 1'b1;
      if (do_alloc)
        done_bits[tail_idx] <= 1'b0;
    end
  end

  // Entry payload captured at allocation.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      ent_pc[tail_idx]       <= bus.alloc_pc;
      ent_reclaim[tail_idx]  <= bus.alloc_reclaim;
      ent_uses_rw[tail_idx]  <= bus.alloc_uses_rw;
      ent_is_store[tail_idx] <= bus.alloc_is_store;
      ent_color[tail_idx]    <= tail[IW];
    end
  end

`ifdef ACTIVE_LIST_STATS_EN
  logic [31:0] st_commits, st_flushes, st_full;
  logic [32:0] commits_sum;
  assign commits_sum          = {1'b0, st_commits} + 33'(n_commit);
  assign bus.stat_commits     = st_commits;
  assign bus.stat_flushes     = st_flushes;
  assign bus.stat_full_cycles = st_full;

  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_commits <= '0;
      st_flushes <= '0;
      st_full    <= '0;
    end else begin
      st_commits <= commits_sum[32] ? '1 : commits_sum[31:0];
      if (flush_accept && (st_flushes != '1))
        st_flushes <= st_flushes + 32'd1;
      if (bus.full && bus.alloc_valid && (st_full != '1))
        st_full <= st_full + 32'd1;
    end
  end
`else
  assign bus.stat_commits     = '0;
  assign bus.stat_flushes     = '0;
  assign bus.stat_full_cycles = '0;
`endif
endmodule

// File: tb/tb_active_list_unit.sv
// tb/tb_active_list_unit.sv - directed scoreboard bench for active_list_unit
module tb_active_list_unit;
  localparam int D  = 8;
  localparam int CW = 2;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  active_list_if #(.DEPTH(D), .COMMIT_WIDTH(CW), .NUM_DONE(2), .PREG_IDX(6), .ADDR_WIDTH(32)) bus();
  active_list_unit #(.DEPTH(D), .COMMIT_WIDTH(CW), .NUM_DONE(2), .PREG_IDX(6), .ADDR_WIDTH(32))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [5:0]  reclaim;
    logic        st;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_tail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.alloc_valid = 0; bus.alloc_pc = '0; bus.alloc_uses_rw = 0;
    bus.alloc_rw_addr = '0; bus.alloc_reclaim = '0; bus.alloc_is_load = 0;
    bus.alloc_is_store = 0; bus.done_valid = '0; bus.done_id = '0;
    bus.flush_valid = 0; bus.flush_id = '0; bus.flush_color = 0;
  endtask

  task automatic sb_check();
    ent_t e;
    for (int j = 0; j < CW; j++) begin
      if (bus.commit_valid[j]) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL sb_extra observed=commit id %0d expected=no commit", bus.commit_id[j*IW +: IW]);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("commit_id", 64'(bus.commit_id[j*IW +: IW]), 64'(e.id));
          chk("commit_pc", 64'(bus.commit_pc[j*32 +: 32]), 64'(e.pc));
          chk("commit_reclaim", 64'(bus.commit_reclaim[j*6 +: 6]), 64'(e.reclaim));
          chk("commit_is_store", 64'(bus.commit_is_store[j]), 64'(e.st));
          chk("commit_uses_rw", 64'(bus.commit_uses_rw[j]), 64'd1);
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    sb_check();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    q.delete();
    m_tail = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic alloc_one(input logic [31:0] pc, input logic [5:0] rc, input logic st);
    ent_t e;
    chk("alloc_id", 64'(bus.alloc_id), 64'(m_tail % D));
    chk("alloc_color", 64'(bus.alloc_color), 64'((m_tail / D) % 2));
    bus.alloc_valid = 1; bus.alloc_pc = pc; bus.alloc_uses_rw = 1;
    bus.alloc_rw_addr = rc + 6'd1; bus.alloc_reclaim = rc; bus.alloc_is_store = st;
    e.id = m_tail % D; e.pc = pc; e.reclaim = rc; e.st = st;
    q.push_back(e);
    m_tail++;
  endtask

  task automatic set_done(input int a, input logic va, input int b, input logic vb);
    bus.done_valid = {vb, va};
    bus.done_id = {3'(b), 3'(a)};
  endtask

  task automatic squash_after(input int f);
    while (q.size() > 0 && q[$].id != f) begin
      void'(q.pop_back());
      m_tail--;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (bus.empty !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(bus.empty), 64'd1);
    chk("drain_queue", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    do_reset();
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_ready", 64'(bus.alloc_ready), 64'd1);
    chk("rst_alloc_id", 64'(bus.alloc_id), 64'd0);
    chk("rst_color", 64'(bus.alloc_color), 64'd0);
    chk("rst_commit", 64'(bus.commit_valid), 64'd0);

    // fill to DEPTH, 9th alloc ignored
    for (int i = 0; i < D; i++) begin
      alloc_one(32'h100 + 32'(i * 4), 6'(i + 10), 1'(i % 3 == 0));
      tick();
    end
    chk("full_flag", 64'(bus.full), 64'd1);
    chk("full_ready", 64'(bus.alloc_ready), 64'd0);
    chk("full_count", 64'(bus.count), 64'd8);
    bus.alloc_valid = 1; bus.alloc_pc = 32'hdead;
    tick();
    chk("full_ignored_count", 64'(bus.count), 64'd8);
    chk("full_ignored_color", 64'(bus.alloc_color), 64'd1);
`ifdef ACTIVE_LIST_STATS_EN
    chk("stat_full_cycles", 64'(bus.stat_full_cycles), 64'd1);
`else
    chk("stat_full_cycles_off", 64'(bus.stat_full_cycles), 64'd0);
`endif
    for (int i = 0; i < D; i += 2) begin
      set_done(i, 1, i + 1, 1);
      tick();
    end
    drain();

    // out-of-order completion, in-order retire
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_one(32'h200 + 32'(i * 4), 6'(i + 30), 1'(i[0]));
      tick();
    end
    set_done(1, 1, 2, 1);
    tick();
    set_done(3, 1, 0, 0);
    tick();
    chk("ooo_commit_none", 64'(bus.commit_valid), 64'd0);
    set_done(0, 1, 0, 0);
    tick();
    chk("ooo_commit_01", 64'(bus.commit_valid), 64'd3);
    tick();
    chk("ooo_commit_23", 64'(bus.commit_valid), 64'd3);
    tick();
    chk("ooo_empty", 64'(bus.empty), 64'd1);

    // accepted flush at id 2
    do_reset();
    for (int i = 0; i < 6; i++) begin
      alloc_one(32'h300 + 32'(i * 4), 6'(i + 40), 1'b0);
      tick();
    end
    bus.flush_valid = 1; bus.flush_id = 3'd2; bus.flush_color = 1'b0;
    #1;
    chk("flush_ready", 64'(bus.alloc_ready), 64'd0);
    squash_after(2);
    tick();
    chk("flush_count", 64'(bus.count), 64'd3);
    chk("flush_alloc_id", 64'(bus.alloc_id), 64'd3);
    set_done(4, 1, 0, 0);
    tick();
    alloc_one(32'h400, 6'd50, 1'b1);
    tick();
    alloc_one(32'h404, 6'd51, 1'b0);
    tick();
    set_done(0, 1, 1, 1);
    tick();
    set_done(2, 1, 3, 1);
    tick();
    tick();
    tick();
    chk("stale_done_count", 64'(bus.count), 64'd1);
    chk("stale_done_commit", 64'(bus.commit_valid), 64'd0);
    set_done(4, 1, 0, 0);
    tick();
    drain();

    // flush with mismatching color is ignored
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_one(32'h500 + 32'(i * 4), 6'(i + 5), 1'b0);
      tick();
    end
    bus.flush_valid = 1; bus.flush_id = 3'd1; bus.flush_color = 1'b1;
    tick();
    chk("badcolor_count", 64'(bus.count), 64'd3);
    chk("badcolor_alloc_id", 64'(bus.alloc_id), 64'd3);
    set_done(0, 1, 1, 1);
    tick();
    set_done(2, 1, 0, 0);
    tick();
    drain();

    // wrap both pointers twice
    do_reset();
    for (int i = 0; i < 20; i++) begin
      alloc_one(32'h1000 + 32'(i * 4), 6'($urandom_range(0, 63)), 1'(i[0]));
      if (i > 0) set_done((m_tail - 2) % D, 1, 0, 0);
      tick();
    end
    chk("wrap_color", 64'(bus.alloc_color), 64'd0);
    set_done((m_tail - 1) % D, 1, 0, 0);
    tick();
    drain();
    chk("wrap_alloc_id", 64'(bus.alloc_id), 64'd4);

    // flush + commit + blocked alloc in one cycle
    do_reset();
    alloc_one(32'h600, 6'd7, 1'b0);
    tick();
    alloc_one(32'h604, 6'd8, 1'b0);
    tick();
    set_done(0, 1, 1, 1);
    tick();
    bus.flush_valid = 1; bus.flush_id = 3'd0; bus.flush_color = 1'b0;
    bus.alloc_valid = 1; bus.alloc_pc = 32'hbad;
    #1;
    chk("same_commit", 64'(bus.commit_valid), 64'd1);
    chk("same_ready", 64'(bus.alloc_ready), 64'd0);
    squash_after(0);
    tick();
    chk("same_count", 64'(bus.count), 64'd0);
    chk("same_empty", 64'(bus.empty), 64'd1);
    chk("same_alloc_id", 64'(bus.alloc_id), 64'd1);
    chk("same_queue", 64'(q.size()), 64'd0);
`ifdef ACTIVE_LIST_STATS_EN
    chk("stat_flushes", 64'(bus.stat_flushes), 64'd1);
    chk("stat_commits", 64'(bus.stat_commits), 64'd1);
`else
    chk("stat_flushes_off", 64'(bus.stat_flushes), 64'd0);
    chk("stat_commits_off", 64'(bus.stat_commits), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
